bitmap_to_location: RTL and testbench



---
 rtl/bitmap_to_location_pkg.sv | 21 ++
 rtl/bitmap_to_location_lead_one.sv | 21 ++
 rtl/bitmap_to_location.sv | 146 ++++++++++++++
 tb/tb_bitmap_to_location.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_to_location_pkg.sv
// Shared HQC vector parameters and the scan state encoding, common to the
// bitmap/location conversion blocks.
package hqc_params;

  localparam int unsigned M          = 15;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned DEPTH      = 17696 / 32;
  localparam int unsigned LOGW       = $clog2(DEPTH);
  localparam int unsigned N_BITS     = 17669;
  localparam int unsigned WEIGHT     = 75;
  localparam int unsigned LOG_WEIGHT = $clog2(WEIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SCAN,
    S_DONE
  } state_t;

endpackage

// File: rtl/bitmap_to_location_lead_one.sv
// Combinational leading-one detector: index of the highest set bit plus a
// flag for an all-zero word.
module lead_one_enc #(
  parameter int unsigned WIDTH = hqc_params::WIDTH,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic [IDXW-1:0]  idx,
  output logic             zero
);

  always_comb begin
    idx  = '0;
    zero = (word == '0);
    // Ascending scan: the last hit wins, which is the most significant one.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (word[i]) idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/bitmap_to_location.sv
// Scans a dense bitmap RAM word by word and emits the positions of its set
// bits in ascending order, checking the total against the expected weight.
module bitmap_to_location
  import hqc_params::*;
#(
  parameter int unsigned M          = hqc_params::M,
  parameter int unsigned WIDTH      = hqc_params::WIDTH,
  parameter int unsigned DEPTH      = hqc_params::DEPTH,
  parameter int unsigned LOGW       = hqc_params::LOGW,
  parameter int unsigned N_BITS     = hqc_params::N_BITS,
  parameter int unsigned WEIGHT     = hqc_params::WEIGHT,
  parameter int unsigned LOG_WEIGHT = hqc_params::LOG_WEIGHT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [LOGW-1:0]       mem_addr,
  input  logic [WIDTH-1:0]      mem_q,
  output logic                  loc_valid,
  output logic [M-1:0]          loc_out,
  output logic [LOG_WEIGHT-1:0] loc_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  weight_err
);

  localparam int unsigned IDXW = $clog2(WIDTH);
  localparam int unsigned CW   = LOG_WEIGHT + 1;
  localparam int unsigned LW   = M + 1;

  state_t                state, state_n;
  logic [LOGW-1:0]       addr, addr_n;
  logic [WIDTH-1:0]      word_reg, word_n;
  logic [CW-1:0]         count, count_n;
  logic                  rd_en_n, loc_valid_n, busy_n, done_n, err_n;
  logic [M-1:0]          loc_out_n;
  logic [LOG_WEIGHT-1:0] loc_addr_n;
  logic [IDXW-1:0]       lead_idx;
  logic                  lead_zero;
  logic [LW-1:0]         loc_full;
  logic                  word_end;

  lead_one_enc #(.WIDTH(WIDTH), .IDXW(IDXW)) u_lead (
    .word (word_reg),
    .idx  (lead_idx),
    .zero (lead_zero)
  );

  // One extra bit so an out-of-range address never wraps below N_BITS.
  assign loc_full = LW'(addr) * LW'(WIDTH) + LW'(WIDTH - 1) - LW'(lead_idx);
  assign mem_addr = addr;

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    word_n      = word_reg;
    count_n     = count;
    rd_en_n     = 1'b0;
    loc_valid_n = 1'b0;
    loc_out_n   = loc_out;
    loc_addr_n  = loc_addr;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = weight_err;
    word_end    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          addr_n  = '0;
          count_n = '0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
          rd_en_n = 1'b1;
        end
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        word_n = mem_q;
        if (mem_q == '0) word_end = 1'b1;
        else             state_n  = S_SCAN;
      end
      S_SCAN: begin
        word_n = word_reg & ~(WIDTH'(1) << lead_idx);
        if (loc_full < LW'(N_BITS) && count < CW'(WEIGHT)) begin
          loc_valid_n = 1'b1;
          loc_out_n   = loc_full[M-1:0];
          loc_addr_n  = count[LOG_WEIGHT-1:0];
          count_n     = count + 1'b1;
        end else begin
          err_n = 1'b1;
        end
        if (word_n == '0 || lead_zero) word_end = 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
        if (count != CW'(WEIGHT)) err_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Empty-word exit shared by LOAD and the last extraction of SCAN.
    if (word_end) begin
      if (addr == LOGW'(DEPTH - 1)) begin
        state_n = S_DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end else begin
        addr_n  = addr + 1'b1;
        state_n = S_FETCH;
        rd_en_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      word_reg   <= '0;
      count      <= '0;
      mem_rd_en  <= 1'b0;
      loc_valid  <= 1'b0;
      loc_out    <= '0;
      loc_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      weight_err <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      word_reg   <= word_n;
      count      <= count_n;
      mem_rd_en  <= rd_en_n;
      loc_valid  <= loc_valid_n;
      loc_out    <= loc_out_n;
      loc_addr   <= loc_addr_n;
      busy       <= busy_n;
      done       <= done_n;
      weight_err <= err_n;
    end
  end

endmodule

// File: tb/tb_bitmap_to_location.sv
// Self-checking bench for bitmap_to_location: a default-weight instance and
// a weight-4 instance, each with its own bitmap RAM model.
module tb_bitmap_to_location;

  localparam int DEPTH = 553;
  localparam int NB    = 17669;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        rd0, rd1;
  logic [9:0]  addr0, addr1;
  logic [31:0] q0, q1;
  logic        lv0, lv1;
  logic [14:0] lo0, lo1;
  logic [6:0]  la0;
  logic [1:0]  la1;
  logic        busy0, busy1, done0, done1, err0, err1;
  logic [31:0] mem0 [DEPTH];
  logic [31:0] mem1 [DEPTH];

  int checks = 0;
  int errors = 0;
  int obs_loc[$], obs_idx[$], exp_loc[$];
  int obs_done_cyc, obs_dones, exp_done_cyc;
  logic obs_err, obs_busy_start, obs_busy_after;
  logic exp_err;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd0) q0 <= mem0[addr0];
    if (rd1) q1 <= mem1[addr1];
  end

  bitmap_to_location dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .mem_rd_en(rd0), .mem_addr(addr0), .mem_q(q0),
    .loc_valid(lv0), .loc_out(lo0), .loc_addr(la0),
    .busy(busy0), .done(done0), .weight_err(err0)
  );

  bitmap_to_location #(.WEIGHT(4), .LOG_WEIGHT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .mem_rd_en(rd1), .mem_addr(addr1), .mem_q(q1),
    .loc_valid(lv1), .loc_out(lo1), .loc_addr(la1),
    .busy(busy1), .done(done1), .weight_err(err1)
  );

  task automatic clear_mem(input int which);
    for (int i = 0; i < DEPTH; i++) begin
      if (which != 0) mem1[i] = '0;
      else            mem0[i] = '0;
    end
  endtask

  task automatic set_loc(input int which, input int loc);
    int w;
    int b;
    w = loc / 32;
    b = 31 - (loc % 32);
    if (which != 0) mem1[w][b] = 1'b1;
    else            mem0[w][b] = 1'b1;
  endtask

  task automatic set_random(input int which, input int n);
    bit used[NB];
    int k;
    int loc;
    k = 0;
    while (k < n) begin
      loc = int'($urandom_range(NB - 1, 0));
      if (!used[loc]) begin
        used[loc] = 1'b1;
        set_loc(which, loc);
        k++;
      end
    end
  endtask

  // Reference: walk every bit position of the flat vector in order.
  function automatic void model(input int which);
    int w;
    int cnt;
    int p;
    logic [31:0] wd;
    w = (which != 0) ? 4 : 75;
    cnt = 0;
    p = 0;
    exp_loc.delete();
    exp_err = 1'b0;
    for (int loc = 0; loc < DEPTH * 32; loc++) begin
      wd = (which != 0) ? mem1[loc / 32] : mem0[loc / 32];
      if (wd[31 - (loc % 32)]) begin
        p++;
        if (loc < NB && cnt < w) begin
          exp_loc.push_back(loc);
          cnt++;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    if (cnt != w) exp_err = 1'b1;
    exp_done_cyc = 2 * DEPTH + p + 1;
  endfunction

  task automatic run_scan(input int which, input bit poke);
    int n;
    logic lv, dn, bz;
    int lo, la;
    obs_loc.delete();
    obs_idx.delete();
    obs_done_cyc = -1;
    obs_dones = 0;
    obs_err = 1'bx;
    obs_busy_start = 1'b0;
    obs_busy_after = 1'bx;
    @(negedge clk);
    if (which != 0) start1 = 1'b1;
    else            start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    n = 1;
    while (n < 3000) begin
      @(negedge clk);
      lv = (which != 0) ? lv1 : lv0;
      dn = (which != 0) ? done1 : done0;
      bz = (which != 0) ? busy1 : busy0;
      lo = (which != 0) ? int'(lo1) : int'(lo0);
      la = (which != 0) ? int'(la1) : int'(la0);
      if (n == 1) obs_busy_start = bz;
      if (lv) begin
        obs_loc.push_back(lo);
        obs_idx.push_back(la);
      end
      if (dn) begin
        obs_dones++;
        if (obs_done_cyc < 0) obs_done_cyc = n;
      end
      if (obs_done_cyc >= 0 && n == obs_done_cyc + 2)
        obs_err = (which != 0) ? err1 : err0;
      if (obs_done_cyc >= 0 && n == obs_done_cyc + 4) begin
        obs_busy_after = bz;
        break;
      end
      if (poke && n < 1000) begin
        if (which != 0) start1 = (n % 97 == 10);
        else            start0 = (n % 97 == 10);
      end
      @(posedge clk);
      n++;
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd0); end
    checks++; if (addr0 !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", addr0); end
    checks++; if (lv0 !== 1'b0) begin errors++; $display("FAIL reset_loc_valid: got %b expected 0", lv0); end
    checks++; if (lo0 !== '0) begin errors++; $display("FAIL reset_loc_out: got %0d expected 0", lo0); end
    checks++; if (la0 !== '0) begin errors++; $display("FAIL reset_loc_addr: got %0d expected 0", la0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_weight_err: got %b expected 0", err0); end
    checks++;
    if ({rd1, addr1, lv1, lo1, la1, busy1, done1, err1} !== '0) begin
      errors++;
      $display("FAIL reset_w4_outputs: got %h expected 0", {rd1, addr1, lv1, lo1, la1, busy1, done1, err1});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_small;
    int exp[4];
    exp = '{0, 31, 32, 17668};
    clear_mem(1);
    mem1[0] = 32'h8000_0001;
    mem1[1] = 32'h8000_0000;
    mem1[552] = 32'h0800_0000;
    run_scan(1, 1'b0);
    checks++;
    if (obs_loc.size() != 4) begin errors++; $display("FAIL small_count: got %0d expected 4", obs_loc.size()); end
    for (int i = 0; i < obs_loc.size() && i < 4; i++) begin
      checks++;
      if (obs_loc[i] !== exp[i] || obs_idx[i] !== i) begin
        errors++;
        $display("FAIL small_loc[%0d]: got loc %0d idx %0d expected loc %0d idx %0d", i, obs_loc[i], obs_idx[i], exp[i], i);
      end
    end
    checks++; if (obs_done_cyc !== 1111) begin errors++; $display("FAIL small_done_cycle: got %0d expected 1111", obs_done_cyc); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL small_weight_err: got %b expected 0", obs_err); end
    checks++; if (obs_busy_start !== 1'b1) begin errors++; $display("FAIL small_busy_start: got %b expected 1", obs_busy_start); end
    checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL small_busy_after: got %b expected 0", obs_busy_after); end
  endtask

  task automatic test_random;
    clear_mem(0);
    set_random(0, 75);
    model(0);
    run_scan(0, 1'b0);
    checks++;
    if (obs_loc.size() != 75) begin errors++; $display("FAIL random_count: got %0d expected 75", obs_loc.size()); end
    for (int i = 0; i < obs_loc.size() && i < exp_loc.size(); i++) begin
      checks++;
      if (obs_loc[i] !== exp_loc[i] || obs_idx[i] !== i) begin
        errors++;
        $display("FAIL random_loc[%0d]: got loc %0d idx %0d expected loc %0d idx %0d", i, obs_loc[i], obs_idx[i], exp_loc[i], i);
      end
    end
    checks++; if (obs_done_cyc !== 1182) begin errors++; $display("FAIL random_done_cycle: got %0d expected 1182", obs_done_cyc); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL random_weight_err: got %b expected 0", obs_err); end
  endtask

  task automatic test_zero;
    clear_mem(0);
    run_scan(0, 1'b0);
    checks++; if (obs_loc.size() != 0) begin errors++; $display("FAIL zero_count: got %0d expected 0", obs_loc.size()); end
    checks++; if (obs_done_cyc !== 1107) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1107", obs_done_cyc); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL zero_weight_err: got %b expected 1", obs_err); end
  endtask

  task automatic test_excess;
    clear_mem(0);
    set_random(0, 76);
    model(0);
    run_scan(0, 1'b0);
    checks++;
    if (obs_loc.size() != 75) begin errors++; $display("FAIL excess_count: got %0d expected 75", obs_loc.size()); end
    for (int i = 0; i < obs_loc.size() && i < exp_loc.size(); i++) begin
      checks++;
      if (obs_loc[i] !== exp_loc[i] || obs_idx[i] !== i) begin
        errors++;
        $display("FAIL excess_loc[%0d]: got loc %0d idx %0d expected loc %0d idx %0d", i, obs_loc[i], obs_idx[i], exp_loc[i], i);
      end
    end
    checks++; if (obs_done_cyc !== 1183) begin errors++; $display("FAIL excess_done_cycle: got %0d expected 1183", obs_done_cyc); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL excess_weight_err: got %b expected 1", obs_err); end
  endtask

  task automatic test_illegal;
    int exp[4];
    exp = '{0, 100, 200, 17668};
    clear_mem(1);
    for (int i = 0; i < 4; i++) set_loc(1, exp[i]);
    mem1[552][0] = 1'b1;
    run_scan(1, 1'b0);
    checks++;
    if (obs_loc.size() != 4) begin errors++; $display("FAIL illegal_count: got %0d expected 4", obs_loc.size()); end
    for (int i = 0; i < obs_loc.size() && i < 4; i++) begin
      checks++;
      if (obs_loc[i] !== exp[i] || obs_idx[i] !== i) begin
        errors++;
        $display("FAIL illegal_loc[%0d]: got loc %0d idx %0d expected loc %0d idx %0d", i, obs_loc[i], obs_idx[i], exp[i], i);
      end
    end
    checks++; if (obs_done_cyc !== 1112) begin errors++; $display("FAIL illegal_done_cycle: got %0d expected 1112", obs_done_cyc); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL illegal_weight_err: got %b expected 1", obs_err); end
  endtask

  task automatic test_start_busy;
    clear_mem(0);
    set_random(0, 75);
    model(0);
    run_scan(0, 1'b1);
    checks++; if (obs_dones != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", obs_dones); end
    checks++; if (obs_done_cyc !== exp_done_cyc) begin errors++; $display("FAIL busy_done_cycle: got %0d expected %0d", obs_done_cyc, exp_done_cyc); end
    checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL busy_restart: got %b expected 0", obs_busy_after); end
    checks++;
    if (obs_loc.size() != exp_loc.size()) begin errors++; $display("FAIL busy_count: got %0d expected %0d", obs_loc.size(), exp_loc.size()); end
    for (int i = 0; i < obs_loc.size() && i < exp_loc.size(); i++) begin
      checks++;
      if (obs_loc[i] !== exp_loc[i]) begin
        errors++;
        $display("FAIL busy_loc[%0d]: got %0d expected %0d", i, obs_loc[i], exp_loc[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    clear_mem(0);
    set_random(0, 75);
    model(0);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    n = 0;
    while (!lv0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (lv0 !== 1'b1) begin errors++; $display("FAIL midreset_reach_scan: got %b expected 1", lv0); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd0, addr0, lv0, lo0, la0, busy0, done0, err0} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0", {rd0, addr0, lv0, lo0, la0, busy0, done0, err0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL midreset_idle: got %b expected 00", {busy0, done0}); end
    run_scan(0, 1'b0);
    checks++;
    if (obs_loc.size() != exp_loc.size()) begin errors++; $display("FAIL midreset_count: got %0d expected %0d", obs_loc.size(), exp_loc.size()); end
    for (int i = 0; i < obs_loc.size() && i < exp_loc.size(); i++) begin
      checks++;
      if (obs_loc[i] !== exp_loc[i] || obs_idx[i] !== i) begin
        errors++;
        $display("FAIL midreset_loc[%0d]: got loc %0d idx %0d expected loc %0d idx %0d", i, obs_loc[i], obs_idx[i], exp_loc[i], i);
      end
    end
    checks++; if (obs_done_cyc !== exp_done_cyc) begin errors++; $display("FAIL midreset_done_cycle: got %0d expected %0d", obs_done_cyc, exp_done_cyc); end
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL midreset_weight_err: got %b expected %b", obs_err, exp_err); end
  endtask

  initial begin
    clear_mem(0);
    clear_mem(1);
    test_reset();
    test_small();
    test_random();
    test_zero();
    test_excess();
    test_illegal();
    test_start_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
